// File: rtl/ladder_scalar_ctrl_pkg.sv
// ladder_scalar_ctrl_pkg
//   Shared definitions for the X25519 ladder scalar scheduler:
//   - X25519 scalar width and first ladder bit index
//   - bit-index width used on the bit_idx output
//   - clamp constant (number of low scalar bits forced to zero)
//   - FSM state encoding (3-bit), also exported on the debug state output
package ladder_scalar_ctrl_pkg;

  localparam int X25519_WID      = 256;
  localparam int X25519_TOP      = 254;
  localparam int IDX_W           = 8;
  localparam int CLAMP_LOW_BITS  = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SWAP  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_FINAL = 3'd3,
    ST_FWAIT = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/ladder_scalar_ctrl_if.sv
// ladder_scalar_ctrl_if
//   Bundles the scheduler's control-side signals.
//   master: the requester / ladder datapath side (drives start, scalar, step_done)
//   slave : the scheduler itself
//
//   Handshake: start is a level sampled only while the scheduler is idle; the
//   cycle it is seen in IDLE is the accepted cycle and scalar is captured then.
//   sw_en is a one-cycle strobe carrying swap (and final_sw on the last one);
//   the consumer answers each strobe with step_done, which is only honoured in
//   the wait state that follows the strobe and is never queued.
//
//   Signals:
//     start      request a scalar multiplication
//     scalar     scalar k
//     step_done  ladder step / final swap consumed
//     swap       swap decision, held until the next decision
//     sw_en      one-cycle enable to cswap
//     final_sw   marks the final conditional swap
//     bit_idx    current ladder bit index
//     busy       scheduler not idle
//     done       one-cycle completion pulse
//     dbg_state  current FSM state
interface ladder_scalar_ctrl_if
  import ladder_scalar_ctrl_pkg::*;
#(
  parameter int WID = X25519_WID
);
  logic             start;
  logic [WID-1:0]   scalar;
  logic             step_done;
  logic             swap;
  logic             sw_en;
  logic             final_sw;
  logic [IDX_W-1:0] bit_idx;
  logic             busy;
  logic             done;
  state_t           dbg_state;

  modport master (
    output start, scalar, step_done,
    input  swap, sw_en, final_sw, bit_idx, busy, done, dbg_state
  );

  modport slave (
    input  start, scalar, step_done,
    output swap, sw_en, final_sw, bit_idx, busy, done, dbg_state
  );
endinterface

// File: rtl/ladder_scalar_ctrl_scalar_clamp.sv
// scalar_clamp
//   Combinational X25519 scalar clamp applied at the scheduler's load mux.
//   CLAMP=1: clear bits [2:0] and bit WID-1, set bit TOP.
//   CLAMP=0: pass the scalar through unchanged.
//   Ports:
//     k_in   scalar as presented
//     k_out  scalar to latch
module scalar_clamp
  import ladder_scalar_ctrl_pkg::*;
#(
  parameter int WID   = X25519_WID,
  parameter int TOP   = X25519_TOP,
  parameter int CLAMP = 1
) (
  input  logic [WID-1:0] k_in,
  output logic [WID-1:0] k_out
);
  localparam logic [WID-1:0] ONE      = {{(WID-1){1'b0}}, 1'b1};
  localparam logic [WID-1:0] CLR_MASK = (ONE << (WID - 1)) | ((ONE << CLAMP_LOW_BITS) - ONE);
  localparam logic [WID-1:0] SET_MASK = ONE << TOP;

  generate
    if (CLAMP != 0) begin : g_clamp
      assign k_out = (k_in & ~CLR_MASK) | SET_MASK;
    end else begin : g_pass
      assign k_out = k_in;
    end
  endgenerate
endmodule

// File: rtl/ladder_scalar_ctrl.sv
// ladder_scalar_ctrl
//   Scalar-bit scheduler for the X25519 Montgomery ladder, feeding cswap.
//   Latches the (optionally clamped) scalar, walks bits TOP..0 and issues one
//   swap decision k[t] ^ k[t+1] per step with a one-cycle sw_en, waiting for
//   step_done after each. Finishes with the final conditional swap (swap =
//   k[0]) and a one-cycle done pulse.
//   Ports:
//     clk  clock, rising edge
//     rst  asynchronous reset, active low
//     bus  ladder_scalar_ctrl_if.slave (see interface header)
//   All outputs are registered and decoded from the next state.
module ladder_scalar_ctrl
  import ladder_scalar_ctrl_pkg::*;
#(
  parameter int WID   = X25519_WID,
  parameter int TOP   = X25519_TOP,
  parameter int CLAMP = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  ladder_scalar_ctrl_if.slave  bus
);
  localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(TOP);

  state_t           state_q, state_n;
  logic [WID-1:0]   k_q, k_n, k_clamped;
  logic [IDX_W-1:0] t_q, t_n;
  logic             prev_q, prev_n;
  logic             swap_q, swap_n;
  logic             sw_en_q, final_sw_q, busy_q, done_q;

  scalar_clamp #(
    .WID   (WID),
    .TOP   (TOP),
    .CLAMP (CLAMP)
  ) u_clamp (
    .k_in  (bus.scalar),
    .k_out (k_clamped)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      t_q     <= TOP_IDX;
      prev_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      k_q     <= k_n;
      t_q     <= t_n;
      prev_q  <= prev_n;
    end
  end

  // The swap value and swap_prev are computed on the transition into SWAP so
  // swap is already valid in the cycle sw_en is high. Entering from IDLE the
  // previous bit is 0, so the first decision is simply k[TOP].
  always_comb begin
    state_n = state_q;
    k_n     = k_q;
    t_n     = t_q;
    prev_n  = prev_q;
    swap_n  = swap_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          k_n     = k_clamped;
          t_n     = TOP_IDX;
          swap_n  = k_clamped[TOP];
          prev_n  = k_clamped[TOP];
          state_n = ST_SWAP;
        end
      end
      ST_SWAP: state_n = ST_WAIT;
      ST_WAIT: begin
        if (bus.step_done) begin
          // t==0 is tested before any decrement, so t never wraps.
          if (t_q == '0) begin
            swap_n  = prev_q;
            state_n = ST_FINAL;
          end else begin
            t_n     = t_q - 1'b1;
            swap_n  = k_q[t_n] ^ prev_q;
            prev_n  = k_q[t_n];
            state_n = ST_SWAP;
          end
        end
      end
      ST_FINAL: state_n = ST_FWAIT;
      ST_FWAIT: begin
        if (bus.step_done) state_n = ST_DONE;
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      swap_q     <= 1'b0;
      sw_en_q    <= 1'b0;
      final_sw_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      swap_q     <= swap_n;
      sw_en_q    <= (state_n == ST_SWAP) || (state_n == ST_FINAL);
      final_sw_q <= (state_n == ST_FINAL);
      busy_q     <= (state_n != ST_IDLE);
      done_q     <= (state_n == ST_DONE);
    end
  end

  assign bus.swap      = swap_q;
  assign bus.sw_en     = sw_en_q;
  assign bus.final_sw  = final_sw_q;
  assign bus.bit_idx   = t_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_ladder_scalar_ctrl.sv
module tb_ladder_scalar_ctrl;
  import ladder_scalar_ctrl_pkg::*;

  localparam int WID = 256;
  localparam int TOP = 254;
  localparam int OW  = 10;  // {final_sw, swap, bit_idx}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ladder_scalar_ctrl_if #(.WID(WID)) bus1 ();
  ladder_scalar_ctrl_if #(.WID(WID)) bus0 ();

  ladder_scalar_ctrl #(.WID(WID), .TOP(TOP), .CLAMP(1)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  ladder_scalar_ctrl #(.WID(WID), .TOP(TOP), .CLAMP(0)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  // ---------------- scoreboard state ----------------
  logic [OW-1:0] exp_q[$];
  logic [OW-1:0] obs_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  int r_n_swen, r_done_cyc;
  bit r_consec, r_busy_at_done, r_busy_after, r_done_after, r_timeout, r_aborted;

  // ---------------- driver tasks ----------------
  task automatic set_in(input bit sel0, input logic st, input logic [WID-1:0] sc, input logic sd);
    if (sel0) begin
      bus0.start = st; bus0.scalar = sc; bus0.step_done = sd;
    end else begin
      bus1.start = st; bus1.scalar = sc; bus1.step_done = sd;
    end
  endtask

  function automatic logic [WID-1:0] rand_scalar();
    logic [WID-1:0] v;
    for (int i = 0; i < WID / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Reference ladder schedule: one entry per sw_en pulse.
  task automatic push_expected(input logic [WID-1:0] k, input bit clamp);
    logic [WID-1:0] kc;
    logic prev;
    kc = k;
    if (clamp) begin
      kc[2:0] = 3'b000;
      kc[WID-1] = 1'b0;
      kc[TOP] = 1'b1;
    end
    prev = 1'b0;
    for (int t = TOP; t >= 0; t--) begin
      exp_q.push_back({1'b0, kc[t] ^ prev, 8'(t)});
      prev = kc[t];
    end
    exp_q.push_back({1'b1, prev, 8'd0});
  endtask

  // mode 0: step_done 1..3 cycles after each sw_en
  // mode 1: step_done tied high
  // mode 2: mode 0 plus step_done during SWAP and start pulses while busy
  // abort_t >= 0: return in the WAIT cycle following the sw_en at bit abort_t
  task automatic drive_run(input bit sel0, input logic [WID-1:0] k, input int mode, input int abort_t);
    int cyc, timer;
    bit prev_swen, hit, done_seen;
    logic s_swen, s_swap, s_final, s_busy, s_done, st, sd;
    logic [7:0] s_idx;
    obs_q.delete();
    r_n_swen = 0; r_consec = 0; r_done_cyc = -1; r_busy_at_done = 0;
    r_busy_after = 1; r_done_after = 1; r_timeout = 0; r_aborted = 0;
    @(negedge clk);
    set_in(sel0, 1'b1, k, 1'b0);
    cyc = 0; timer = 0; prev_swen = 0; hit = 0; done_seen = 0;
    while (!done_seen && !r_timeout && !r_aborted) begin
      @(negedge clk);
      cyc++;
      s_swen  = sel0 ? bus0.sw_en    : bus1.sw_en;
      s_swap  = sel0 ? bus0.swap     : bus1.swap;
      s_final = sel0 ? bus0.final_sw : bus1.final_sw;
      s_busy  = sel0 ? bus0.busy     : bus1.busy;
      s_done  = sel0 ? bus0.done     : bus1.done;
      s_idx   = sel0 ? bus0.bit_idx  : bus1.bit_idx;
      st = 1'b0; sd = 1'b0;
      if (hit) begin
        r_aborted = 1;
      end else begin
        if (s_swen) begin
          obs_q.push_back({s_final, s_swap, s_idx});
          r_n_swen++;
          if (prev_swen) r_consec = 1;
          if (abort_t >= 0 && !s_final && s_idx == 8'(abort_t)) hit = 1;
        end
        prev_swen = s_swen;
        if (s_done) begin
          done_seen = 1;
          r_done_cyc = cyc;
          r_busy_at_done = s_busy;
        end else begin
          if (timer > 0) begin
            timer--;
            if (timer == 0) sd = 1'b1;
          end
          if (s_swen) timer = 1 + $urandom_range(0, 2);
          if (mode == 1) sd = 1'b1;
          if (mode == 2) begin
            if (s_swen) sd = 1'b1;
            if (cyc % 7 == 3) st = 1'b1;
          end
          if (cyc > 3000) r_timeout = 1;
        end
      end
      set_in(sel0, st, ~k, sd);
    end
    if (done_seen) begin
      @(negedge clk);
      r_busy_after = sel0 ? bus0.busy : bus1.busy;
      r_done_after = sel0 ? bus0.done : bus1.done;
    end
    set_in(sel0, 1'b0, ~k, 1'b0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    set_in(1'b0, 1'b1, rand_scalar(), 1'b1);
    set_in(1'b1, 1'b1, rand_scalar(), 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (bus1.busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bus1.busy); else n_pass++;
    n_checks++; if (bus1.sw_en !== 1'b0) $display("FAIL reset_sw_en got=%b exp=0", bus1.sw_en); else n_pass++;
    n_checks++; if (bus1.swap !== 1'b0) $display("FAIL reset_swap got=%b exp=0", bus1.swap); else n_pass++;
    n_checks++; if (bus1.final_sw !== 1'b0) $display("FAIL reset_final_sw got=%b exp=0", bus1.final_sw); else n_pass++;
    n_checks++; if (bus1.done !== 1'b0) $display("FAIL reset_done got=%b exp=0", bus1.done); else n_pass++;
    n_checks++; if (bus1.bit_idx !== 8'd254) $display("FAIL reset_bit_idx got=%0d exp=254", bus1.bit_idx); else n_pass++;
    n_checks++; if (bus1.dbg_state !== ST_IDLE) $display("FAIL reset_state got=%0d exp=%0d", bus1.dbg_state, ST_IDLE); else n_pass++;
    n_checks++; if (bus0.bit_idx !== 8'd254) $display("FAIL reset_bit_idx0 got=%0d exp=254", bus0.bit_idx); else n_pass++;
    set_in(1'b0, 1'b0, '0, 1'b0);
    set_in(1'b1, 1'b0, '0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (bus1.busy !== 1'b0) $display("FAIL post_reset_idle got=%b exp=0", bus1.busy); else n_pass++;
  endtask

  task automatic test_clamp_zero();
    logic [OW-1:0] e, o;
    exp_q.delete();
    push_expected('0, 1'b1);
    drive_run(1'b0, '0, 0, -1);
    n_checks++; if (r_timeout !== 1'b0) $display("FAIL clamp0_timeout got=%b exp=0", r_timeout); else n_pass++;
    n_checks++; if (r_n_swen != 256) $display("FAIL clamp0_sw_en_count got=%0d exp=256", r_n_swen); else n_pass++;
    n_checks++; if (r_consec !== 1'b0) $display("FAIL clamp0_sw_en_back_to_back got=%b exp=0", r_consec); else n_pass++;
    n_checks++; if (r_busy_at_done !== 1'b1) $display("FAIL clamp0_busy_at_done got=%b exp=1", r_busy_at_done); else n_pass++;
    n_checks++; if (r_busy_after !== 1'b0) $display("FAIL clamp0_busy_after_done got=%b exp=0", r_busy_after); else n_pass++;
    n_checks++; if (r_done_after !== 1'b0) $display("FAIL clamp0_done_single got=%b exp=0", r_done_after); else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      n_checks++;
      if (o !== e) $display("FAIL clamp0_step got=%h exp=%h", o, e); else n_pass++;
    end
  endtask

  task automatic test_clamp_off();
    logic [OW-1:0] e, o;
    logic [WID-1:0] k;
    k = '0; k[0] = 1'b1;
    exp_q.delete();
    push_expected(k, 1'b0);
    drive_run(1'b1, k, 0, -1);
    n_checks++; if (r_timeout !== 1'b0) $display("FAIL noclamp_timeout got=%b exp=0", r_timeout); else n_pass++;
    n_checks++; if (r_n_swen != 256) $display("FAIL noclamp_sw_en_count got=%0d exp=256", r_n_swen); else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      n_checks++;
      if (o !== e) $display("FAIL noclamp_step got=%h exp=%h", o, e); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [OW-1:0] e, o;
    logic [WID-1:0] k;
    k = rand_scalar();
    exp_q.delete();
    push_expected(k, 1'b1);
    drive_run(1'b0, k, 1, -1);
    n_checks++; if (r_done_cyc != 513) $display("FAIL b2b_done_cycle got=%0d exp=513", r_done_cyc); else n_pass++;
    n_checks++; if (r_consec !== 1'b0) $display("FAIL b2b_sw_en_back_to_back got=%b exp=0", r_consec); else n_pass++;
    n_checks++; if (r_n_swen != 256) $display("FAIL b2b_sw_en_count got=%0d exp=256", r_n_swen); else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      n_checks++;
      if (o !== e) $display("FAIL b2b_step got=%h exp=%h", o, e); else n_pass++;
    end
  endtask

  task automatic test_ignored_inputs();
    logic [OW-1:0] e, o;
    logic [WID-1:0] k;
    k = rand_scalar();
    exp_q.delete();
    push_expected(k, 1'b1);
    drive_run(1'b0, k, 2, -1);
    n_checks++; if (r_timeout !== 1'b0) $display("FAIL ignore_timeout got=%b exp=0", r_timeout); else n_pass++;
    n_checks++; if (r_n_swen != 256) $display("FAIL ignore_sw_en_count got=%0d exp=256", r_n_swen); else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      n_checks++;
      if (o !== e) $display("FAIL ignore_step got=%h exp=%h", o, e); else n_pass++;
    end
  endtask

  task automatic test_reset_midrun();
    logic [OW-1:0] e, o;
    logic [WID-1:0] k;
    k = rand_scalar();
    exp_q.delete();
    push_expected(k, 1'b1);
    drive_run(1'b0, k, 0, 100);
    n_checks++; if (r_aborted !== 1'b1) $display("FAIL abort_reached got=%b exp=1", r_aborted); else n_pass++;
    n_checks++; if (bus1.dbg_state !== ST_WAIT) $display("FAIL abort_in_wait got=%0d exp=%0d", bus1.dbg_state, ST_WAIT); else n_pass++;
    n_checks++; if (obs_q.size() != 155) $display("FAIL abort_prefix_len got=%0d exp=155", obs_q.size()); else n_pass++;
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_checks++;
      if (o !== e) $display("FAIL abort_prefix_step got=%h exp=%h", o, e); else n_pass++;
    end
    rst = 1'b0;
    #1;
    n_checks++; if (bus1.bit_idx !== 8'd254) $display("FAIL abort_bit_idx got=%0d exp=254", bus1.bit_idx); else n_pass++;
    n_checks++; if ({bus1.sw_en, bus1.swap, bus1.final_sw, bus1.busy, bus1.done} !== 5'b0)
      $display("FAIL abort_outputs got=%b exp=00000", {bus1.sw_en, bus1.swap, bus1.final_sw, bus1.busy, bus1.done});
    else n_pass++;
    n_checks++; if (bus1.dbg_state !== ST_IDLE) $display("FAIL abort_state got=%0d exp=%0d", bus1.dbg_state, ST_IDLE); else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    k = rand_scalar();
    exp_q.delete();
    push_expected(k, 1'b1);
    drive_run(1'b0, k, 0, -1);
    n_checks++; if (r_n_swen != 256) $display("FAIL rerun_sw_en_count got=%0d exp=256", r_n_swen); else n_pass++;
    n_checks++; if (r_done_cyc < 0) $display("FAIL rerun_done got=%0d exp=>0", r_done_cyc); else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      n_checks++;
      if (o !== e) $display("FAIL rerun_step got=%h exp=%h", o, e); else n_pass++;
    end
  endtask

  // Downstream cswap model: tags 0/1 start in (a,b); each swap exchanges them.
  task automatic test_random();
    logic [OW-1:0] e, o;
    logic [WID-1:0] k;
    logic a, b, tmp, k0;
    for (int r = 0; r < 4; r++) begin
      k = rand_scalar();
      k0 = 1'b0;  // clamp always clears bit 0
      exp_q.delete();
      push_expected(k, 1'b1);
      drive_run(1'b0, k, 0, -1);
      n_checks++; if (r_timeout !== 1'b0) $display("FAIL rand_timeout got=%b exp=0", r_timeout); else n_pass++;
      a = 1'b0; b = 1'b1;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
        n_checks++;
        if (o !== e) $display("FAIL rand_step got=%h exp=%h", o, e); else n_pass++;
        if (e[9]) begin
          n_checks++;
          if (a !== k0) $display("FAIL rand_parity_before_final got=%b exp=%b", a, k0); else n_pass++;
          n_checks++;
          if (o[8] !== k0) $display("FAIL rand_final_swap got=%b exp=%b", o[8], k0); else n_pass++;
        end
        if (o[8] === 1'b1) begin tmp = a; a = b; b = tmp; end
      end
      n_checks++;
      if ({a, b} !== 2'b01) $display("FAIL rand_cswap_restored got=%b exp=01", {a, b}); else n_pass++;
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst = 1'b0;
    set_in(1'b0, 1'b0, '0, 1'b0);
    set_in(1'b1, 1'b0, '0, 1'b0);
    test_reset();
    test_clamp_zero();
    test_clamp_off();
    test_back_to_back();
    test_ignored_inputs();
    test_reset_midrun();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
